// File: rtl/divsqrt_issue.sv
// divsqrt_issue: single-op initiator for the Goldschmidt divide/sqrt datapath controller
//
// Accepts one request on a valid/ready port and issues it to the datapath
// as a one-cycle dp_start with operands held stable.  It then waits for
// dp_done, or for the watchdog to expire, and returns the result on a
// valid/ready response port.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   req_valid/req_ready            request handshake
//   req_op/req_a/req_b/req_tag     op (0 div, 1 sqrt), operands, caller tag
//   dp_start/dp_op_type/dp_a/dp_b  datapath issue (operands stable ISSUE..WAIT)
//   dp_done/dp_error/dp_q/dp_rem   datapath completion
//   rsp_valid/rsp_ready            response handshake
//   rsp_q/rsp_rem/rsp_tag/rsp_err  result, remainder, tag, error-or-timeout
//   busy                           high whenever not IDLE
//
// Optional (define DIVSQRT_ISSUE_STATS_EN): saturating 32-bit counters
//   stat_ops, stat_errs and stat_timeouts, which count at the response handshake.
module divsqrt_issue #(
    parameter int WIDTH   = 64,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             dp_start,
    output logic             dp_op_type,
    output logic [WIDTH-1:0] dp_a,
    output logic [WIDTH-1:0] dp_b,
    input  logic             dp_done,
    input  logic             dp_error,
    input  logic [WIDTH-1:0] dp_q,
    input  logic [WIDTH-1:0] dp_rem,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_q,
    output logic [WIDTH-1:0] rsp_rem,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             busy
`ifdef DIVSQRT_ISSUE_STATS_EN
    ,
    output logic [31:0]      stat_ops,
    output logic [31:0]      stat_errs,
    output logic [31:0]      stat_timeouts
`endif
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           r_state, w_next;
    logic [7:0]       r_cnt;
    logic             r_op, r_err;
    logic [WIDTH-1:0] r_a, r_b, r_q, r_rem;
    logic [TAG_W-1:0] r_tag;
    logic             w_fire, w_hs, w_to;

    assign w_fire = req_valid & req_ready;
    assign w_hs   = rsp_valid & rsp_ready;
    assign w_to   = r_cnt == 8'(TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_fire ? ISSUE : IDLE;
            ISSUE:   w_next = WAIT;
            WAIT:    w_next = (dp_done | w_to) ? RESP : WAIT;
            RESP:    w_next = rsp_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (r_state == IDLE) & ~reset;
        busy      = (r_state != IDLE) & ~reset;
        dp_start  = r_state == ISSUE;
        rsp_valid = r_state == RESP;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            {r_op, r_a, r_b, r_tag} <= '0;
            {r_q, r_rem, r_err}     <= '0;
            r_cnt                   <= '0;
        end else begin
            if (w_fire) {r_op, r_a, r_b, r_tag} <= {req_op, req_a, req_b, req_tag};
            if (r_state == ISSUE) r_cnt <= '0;
            if (r_state == WAIT) begin
                r_cnt <= r_cnt + 8'd1;
                // dp_done takes priority over a watchdog expiry in the same cycle
                if (dp_done)   {r_q, r_rem, r_err} <= {dp_q, dp_rem, dp_error};
                else if (w_to) {r_q, r_rem, r_err} <= {{(2*WIDTH){1'b0}}, 1'b1};
            end
        end
    end

    assign dp_op_type = r_op;
    assign dp_a       = r_a;
    assign dp_b       = r_b;
    assign rsp_q      = r_q;
    assign rsp_rem    = r_rem;
    assign rsp_tag    = r_tag;
    assign rsp_err    = r_err;

`ifdef DIVSQRT_ISSUE_STATS_EN
    // r_timed_out remembers whether the pending response came from the watchdog
    logic r_timed_out;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timed_out   <= 1'b0;
            stat_ops      <= '0;
            stat_errs     <= '0;
            stat_timeouts <= '0;
        end else begin
            if (r_state == WAIT && (dp_done | w_to)) r_timed_out <= ~dp_done;
            if (w_hs) begin
                stat_ops      <= stat_ops + {31'd0, ~&stat_ops};
                stat_errs     <= stat_errs + {31'd0, r_err & ~&stat_errs};
                stat_timeouts <= stat_timeouts + {31'd0, r_timed_out & ~&stat_timeouts};
            end
        end
    end
`else
    logic w_unused;
    assign w_unused = w_hs;
`endif
endmodule
